dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter: LATENCY, 10, cycles from request acceptance to ack; legal range 1..255.
REQ-002 Parameter: DEPTH_LINES, 512, number of 256-bit lines; power of two.
REQ-003 Port: clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 Port: rst_i  input  1  reset, asynchronous, active-high.
REQ-005 Port: enable_i  input  1  request valid from the cache controller.
REQ-006 Port: write_i  input  1  1 = line write, 0 = line read; qualified by enable_i.
REQ-007 Port: addr_i  input  32  byte address; bits [4:0] ignored; line index = addr_i[5+log2(DEPTH_LINES)-1:5]; upper bits ignored (wrap).
REQ-008 Port: data_i  input  256  write line data.
REQ-009 Port: ack_o  output  1  one-cycle completion pulse.
REQ-010 Port: data_o  output  256  read line data.

Function
REQ-011 FSM states: IDLE, BUSY, ACK.
REQ-012 IDLE: enable_i=1 at an edge -> latch write_i, line index and data_i; load counter with LATENCY-1; go BUSY.
REQ-013 BUSY: counter decrements each edge; at counter=0 go ACK; LATENCY=1 -> BUSY lasts one cycle.
REQ-014 ack_o is registered, high only in ACK, exactly one cycle; first ack cycle is LATENCY+1 cycles after the accepting edge.
REQ-015 Read: data_o = stored line at latched index, registered on the edge entering ACK; valid while ack_o=1; held until the next read completes.
REQ-016 Write: latched data_i committed to the array on the edge leaving ACK; data_o unchanged by writes.
REQ-017 Request fields are sampled only at acceptance; input changes during BUSY/ACK have no effect.
REQ-018 enable_i low during BUSY -> abort: return to IDLE, no ack, no commit.
REQ-019 ACK always goes to IDLE; if enable_i is still high in the first IDLE cycle, a new request is accepted on that edge (writeback-then-refill back-to-back; 1-cycle turnaround).
REQ-020 Read following a write to the same line returns the written data.
REQ-021 Never more than one outstanding request; no request queuing.

Reset
REQ-022 rst_i=1 forces state IDLE, counter 0, ack_o 0, data_o 0, latched request cleared, regardless of clock.
REQ-023 Reset during BUSY/ACK aborts the request; a pending write is not committed.
REQ-024 Array contents are not reset; reads of never-written lines return the simulation-initialised value (X in RTL).

Structure
REQ-025 Package dmem_pkg holds LINE_WIDTH=256, ADDR_WIDTH=32, OFFSET_BITS=5 and the FSM state encoding.
REQ-026 Storage is sub-module dmem_line_array: single-port, synchronous write, registered read, DEPTH_LINES x 256.
REQ-027 FSM, latency counter and request latch live in dmem_responder; no other sub-modules.

Verification
REQ-028 Reset, write line 0x00000040 with data 0xA5 repeated x32, LATENCY=10 -> ack_o on cycle 11 after acceptance for one cycle; then read 0x00000040 -> ack on cycle 11, data_o = written pattern.
REQ-029 Back-to-back: write 0x00000400 held with enable_i=1, write_i dropped on the ack edge -> read accepted in the first IDLE cycle, second ack exactly LATENCY+2 cycles after the first ack.
REQ-030 Alias: write 0x00004000 (index 0), read 0x00000000 -> same data returned (DEPTH_LINES=512).
REQ-031 Abort: write request to 0x00000080, drop enable_i in BUSY cycle 3 -> no ack; subsequent read of 0x00000080 returns prior contents.
REQ-032 Reset mid-write: assert rst_i in BUSY -> ack_o=0, data_o=0 immediately; line unchanged on later read.
REQ-033 LATENCY=1: read -> ack_o in the second cycle after acceptance; changing addr_i during BUSY does not alter returned data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// LINE_WIDTH  : width of one memory line in bits
// ADDR_WIDTH  : width of the byte address bus
// OFFSET_BITS : byte-offset bits inside a line (ignored for indexing)
// CNT_WIDTH   : width of the latency counter (LATENCY is at most 255)
// state_e     : responder FSM encoding
package dmem_pkg;
  localparam int LINE_WIDTH  = 256;
  localparam int ADDR_WIDTH  = 32;
  localparam int OFFSET_BITS = 5;
  localparam int CNT_WIDTH   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;
endpackage

// File: rtl/dmem_line_array.sv
// Line storage for the responder: single port, synchronous write,
// registered read. The storage itself is never reset; only the read
// register is cleared so the responder's data output starts at zero.
// Ports:
//   clk_i     clock (rising edge)
//   rst_i     asynchronous active-high reset of the read register
//   we_i      write strobe for line idx_i
//   re_i      read strobe; loads rdata_o from line idx_i
//   idx_i     line index
//   wdata_i   write line data
//   rdata_o   registered read data, held between reads
module dmem_line_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LINES = 512,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o
);

  logic [LINE_WIDTH-1:0] mem_q [DEPTH_LINES];
  logic [LINE_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency line responder for a cache controller. A request is
// accepted in IDLE, held in BUSY for LATENCY cycles, then acknowledged
// for exactly one cycle in ACK. Reads return the line on data_o while
// ack_o is high; writes commit to the array on the edge leaving ACK.
// Dropping enable_i during BUSY abandons the request.
// Ports:
//   clk_i     clock (rising edge)
//   rst_i     asynchronous active-high reset
//   enable_i  request valid
//   write_i   1 = line write, 0 = line read
//   addr_i    byte address; line index taken from the bits above the offset
//   data_i    write line data
//   ack_o     one-cycle completion pulse
//   data_o    read line data, held until the next read completes
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY     = 10,
  parameter int DEPTH_LINES = 512
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  write_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LINE_WIDTH-1:0] data_i,
  output logic                  ack_o,
  output logic [LINE_WIDTH-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   write_q, write_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [LINE_WIDTH-1:0]  wdata_q, wdata_d;
  logic                   ack_q;
  logic                   arr_we;
  logic                   arr_re;

  // Address bits outside the line index are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{addr_i[ADDR_WIDTH-1:OFFSET_BITS+IDX_W],
                         addr_i[OFFSET_BITS-1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          write_d = write_i;
          idx_d   = addr_i[OFFSET_BITS+IDX_W-1:OFFSET_BITS];
          wdata_d = data_i;
        end
      end
      BUSY: begin
        if (!enable_i) begin
          // Abort takes priority over completion: no ack, no commit.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ACK;
          // Read data lands in the array's output register on the same
          // edge that enters ACK, so it is valid together with ack_o.
          arr_re  = !write_q;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        arr_we  = write_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ack_q   <= (state_d == ACK);
    end
  end

  dmem_line_array #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (arr_we),
    .re_i    (arr_re),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (data_o)
  );

  assign ack_o = ack_q;

endmodule
